// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
//   Stalls the front end on load-use hazards that forwarding cannot cover,
//   flushes IF/ID and ID/EX on taken branches, and sequences the multi-cycle
//   MUL/DIV unit with an EX freeze and a watchdog that halts the pipe.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_rs1/id_rs2, id_use_rs1/2     source registers of the decoding instruction
//   ex_memRead, ex_rd               load in EX and its destination
//   ex_md_op                        MUL/DIV in EX
//   ex_br_taken                     branch/jump in EX resolved taken
//   md_done                         MUL/DIV result valid pulse
//   pc_en, ifid_en, idex_en         pipeline register write enables
//   ifid_flush, idex_flush          load NOP / bubble into IF/ID, ID/EX
//   exmem_bubble                    EX/MEM loads bubble instead of EX result
//   md_start                        MUL/DIV start pulse
//   md_timeout                      sticky watchdog error
//   stall_cycles                    saturating count of cycles with pc_en==0
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_RUN     | normal flow; hazard / branch / MD-issue decisions
// S_MD_WAIT | EX frozen waiting for md_done; watchdog counting
// S_HALT    | watchdog expired; pipeline frozen until reset

module hazard_ctrl #(
   parameter int MD_TIMEOUT = 34,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_memRead,
   input  logic [4:0]       ex_rd,
   input  logic             ex_md_op,
   input  logic             ex_br_taken,
   input  logic             md_done,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_bubble,
   output logic             md_start,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int WD_W = $clog2(MD_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_MD_WAIT = 2'd1,
      S_HALT    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             md_timeout_q, md_timeout_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic load_use;
   logic wd_expire;

   assign load_use = ex_memRead && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (ex_rd == id_rs1)) ||
                      (id_use_rs2 && (ex_rd == id_rs2)));

   // Last waiting cycle without md_done: the error is flagged in this very
   // cycle and then held by the sticky register.
   assign wd_expire = (state_q == S_MD_WAIT) && !md_done &&
                      (wd_q == WD_W'(MD_TIMEOUT - 1));

   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_bubble = 1'b0;
      md_start     = 1'b0;
      state_d      = state_q;
      wd_d         = wd_q;
      md_timeout_d = md_timeout_q;

      case (state_q)
         S_RUN: begin
            if (ex_br_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (ex_md_op) begin
               md_start     = 1'b1;
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_en      = 1'b0;
               exmem_bubble = 1'b1;
               wd_d         = '0;
               state_d      = S_MD_WAIT;
            end else if (load_use) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end
         end
         S_MD_WAIT: begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            if (md_done) begin
               // Result goes to EX/MEM; bubble the MD op out of ID/EX so it
               // is not issued again when the front end resumes.
               idex_flush = 1'b1;
               wd_d       = '0;
               state_d    = S_RUN;
            end else begin
               exmem_bubble = 1'b1;
               wd_d         = wd_q + 1'b1;
               if (wd_expire) begin
                  md_timeout_d = 1'b1;
                  state_d      = S_HALT;
               end
            end
         end
         S_HALT: begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase

      if (!rst_n) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         ifid_flush   = 1'b0;
         idex_flush   = 1'b0;
         exmem_bubble = 1'b0;
         md_start     = 1'b0;
      end

      stall_d = stall_q;
      if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_RUN;
         wd_q         <= '0;
         md_timeout_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         wd_q         <= wd_d;
         md_timeout_q <= md_timeout_d;
         stall_q      <= stall_d;
      end
   end

   assign md_timeout   = md_timeout_q || wd_expire;
   assign stall_cycles = stall_q;

endmodule
